// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared widths, FSM state type and output quantiser for the audio decimator.
package audio_pkg;

  localparam int ADC_W = 12;
  localparam int AUDIO_W = 8;
  localparam logic [ADC_W-1:0] ADC_MIDSCALE = 12'd2048;

  typedef enum logic [1:0] {IDLE, WAIT_ADC, ACCUM, EMIT} dec_state_t;

  // Drop the 4 LSBs of a signed 13-bit offset-removed average and clamp to the 8-bit audio range.
  function automatic logic [AUDIO_W-1:0] to_audio(input logic signed [ADC_W:0] diff);
    logic signed [ADC_W-4:0] q;
    q = diff[ADC_W:4];
    if (q > 9'sd127) return 8'h7f;
    else if (q < -9'sd128) return 8'h80;
    else return q[AUDIO_W-1:0];
  endfunction

endpackage

// File: rtl/req_ticker.sv
// rtl/req_ticker.sv - free-running modulo counter that fires one ADC request tick per wrap.
module req_ticker #(
  parameter int CYCLES_PER_REQ = 1024
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic tick_out
);

  localparam int CW = (CYCLES_PER_REQ > 1) ? $clog2(CYCLES_PER_REQ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_REQ - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  assign tick_out = (cnt == LAST);

endmodule

// File: rtl/audio_decimator.sv
// rtl/audio_decimator.sv - requests ADC samples, averages DECIM of them and emits signed 8-bit audio.
// DECIM_DC_TRACK_EN: replaces the fixed midscale offset with a slow 12.8 DC-tracking offset.
module audio_decimator
  import audio_pkg::*;
#(
  parameter int CYCLES_PER_REQ = 1024,
  parameter int DECIM          = 8,
  parameter int TIMEOUT        = 64
) (
  input  logic               clk_in,
  input  logic               rst_in,
  output logic               adc_req_out,
  input  logic [ADC_W-1:0]   adc_data_in,
  input  logic               adc_valid_in,
  output logic [AUDIO_W-1:0] audio_out,
  output logic               audio_valid_out,
  output logic               overrun_out,
  output logic               timeout_out
);

  localparam int LOG2D = $clog2(DECIM);
  localparam int ACC_W = ADC_W + LOG2D;
  localparam int CNT_W = LOG2D + 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  dec_state_t state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ADC_W-1:0] last_raw;
  logic [TW-1:0]    timer;
  logic             tick;

  logic [ACC_W-1:0]      acc_sum;
  logic [CNT_W-1:0]      cnt_next;
  logic [ADC_W-1:0]      avg_next;
  logic [ADC_W-1:0]      offset_int;
  logic signed [ADC_W:0] diff;

  req_ticker #(.CYCLES_PER_REQ(CYCLES_PER_REQ)) u_ticker (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .tick_out(tick)
  );

`ifdef DECIM_DC_TRACK_EN
  logic [ADC_W+7:0]      offset_q;
  logic signed [ADC_W+8:0] track_delta;

  assign offset_int  = offset_q[ADC_W+7:8];
  assign track_delta = $signed({1'b0, acc[ACC_W-1:LOG2D], 8'd0}) - $signed({1'b0, offset_q});

  // acc still holds the full block sum during EMIT, so the tracker sees the same average as the output.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) offset_q <= {ADC_MIDSCALE, 8'd0};
    else if (state == EMIT) offset_q <= offset_q + (ADC_W+8)'(track_delta >>> 8);
  end
`else
  assign offset_int = ADC_MIDSCALE;
`endif

  assign acc_sum  = acc + ACC_W'(last_raw);
  assign cnt_next = cnt + 1'b1;
  assign avg_next = acc_sum[ACC_W-1:LOG2D];
  assign diff     = $signed({1'b0, avg_next}) - $signed({1'b0, offset_int});

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      acc             <= '0;
      cnt             <= '0;
      last_raw        <= ADC_MIDSCALE;
      timer           <= '0;
      adc_req_out     <= 1'b0;
      audio_out       <= '0;
      audio_valid_out <= 1'b0;
      overrun_out     <= 1'b0;
      timeout_out     <= 1'b0;
    end else begin
      audio_valid_out <= 1'b0;
      overrun_out     <= 1'b0;
      timeout_out     <= 1'b0;
      if (tick && state != IDLE) overrun_out <= 1'b1;
      case (state)
        IDLE: if (tick) begin
          state       <= WAIT_ADC;
          adc_req_out <= 1'b1;
          timer       <= '0;
        end
        WAIT_ADC: begin
          if (adc_valid_in) begin
            last_raw    <= adc_data_in;
            adc_req_out <= 1'b0;
            state       <= ACCUM;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            timeout_out <= 1'b1;
            adc_req_out <= 1'b0;
            state       <= ACCUM;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        // The output is registered on the way into EMIT so the strobe is visible during EMIT itself.
        ACCUM: begin
          acc <= acc_sum;
          cnt <= cnt_next;
          if (cnt_next == CNT_W'(DECIM)) begin
            state           <= EMIT;
            audio_out       <= to_audio(diff);
            audio_valid_out <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        EMIT: begin
          acc   <= '0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_decimator.sv
// tb/tb_audio_decimator.sv - directed bench for audio_decimator (16-cycle ticks, DECIM=4, TIMEOUT=8).
module tb_audio_decimator;

  logic clk;
  logic rst;

  logic        adc_req0, adc_valid0, audio_valid0, overrun0, timeout0;
  logic [11:0] adc_data0;
  logic [7:0]  audio_out0;

  logic        adc_req1, adc_valid1, audio_valid1, overrun1, timeout1;
  logic [11:0] adc_data1;
  logic [7:0]  audio_out1;

  audio_decimator #(.CYCLES_PER_REQ(16), .DECIM(4), .TIMEOUT(8)) dut (
    .clk_in(clk), .rst_in(rst), .adc_req_out(adc_req0), .adc_data_in(adc_data0),
    .adc_valid_in(adc_valid0), .audio_out(audio_out0), .audio_valid_out(audio_valid0),
    .overrun_out(overrun0), .timeout_out(timeout0)
  );

  // Second instance with a long timeout so a 20-cycle ADC delay spans a tick instead of expiring.
  audio_decimator #(.CYCLES_PER_REQ(16), .DECIM(4), .TIMEOUT(32)) dut_slow (
    .clk_in(clk), .rst_in(rst), .adc_req_out(adc_req1), .adc_data_in(adc_data1),
    .adc_valid_in(adc_valid1), .audio_out(audio_out1), .audio_valid_out(audio_valid1),
    .overrun_out(overrun1), .timeout_out(timeout1)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int vcyc = 0;
  int spur_cyc = -1;
  logic [11:0] tab0 [4];
  bit          mute0 [4];
  int wc0 = 0, pos0 = 0, wc1 = 0, n1 = 0;
  int e0_first, e1_first, a1_first, ovr0, ovr1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (adc_valid0) vcyc = cyc;
    cyc = cyc + 1;
  end

  // ADC model for dut: answers 3 cycles into each request unless that slot is muted.
  always @(negedge clk) begin
    adc_valid0 = 1'b0;
    if (rst) begin
      wc0 = 0;
      pos0 = 0;
    end else if (adc_req0) begin
      wc0++;
      if (wc0 == 3 && !mute0[pos0]) begin
        adc_valid0 = 1'b1;
        adc_data0  = tab0[pos0];
      end
    end else begin
      if (wc0 != 0) begin
        wc0 = 0;
        pos0 = (pos0 + 1) % 4;
      end
      if (cyc == spur_cyc) begin
        adc_valid0 = 1'b1;
        adc_data0  = 12'd0;
      end
    end
  end

  always @(negedge clk) begin
    adc_valid1 = 1'b0;
    if (rst) begin
      wc1 = 0;
      n1 = 0;
    end else if (adc_req1) begin
      wc1++;
      if (wc1 == ((n1 == 0) ? 20 : 3)) begin
        adc_valid1 = 1'b1;
        adc_data1  = 12'd3000;
      end
    end else if (wc1 != 0) begin
      wc1 = 0;
      n1++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      e0_first = -1; e1_first = -1; a1_first = 0; ovr0 = 0; ovr1 = 0;
    end else begin
      if (audio_valid0 && e0_first < 0) e0_first = cyc;
      if (audio_valid1 && e1_first < 0) begin
        e1_first = cyc;
        a1_first = $signed(audio_out1);
      end
      if (overrun0) ovr0++;
      if (overrun1) ovr1++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic set_tab(input int a, input int b, input int c, input int d);
    tab0[0] = 12'(a); tab0[1] = 12'(b); tab0[2] = 12'(c); tab0[3] = 12'(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_emit(input string tag, output int v);
    int n;
    n = 0;
    @(negedge clk);
    while (!audio_valid0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!audio_valid0) check({tag, "_strobe"}, int'(audio_valid0), 1);
    v = $signed(audio_out0);
  endtask

  initial begin
    int v, t1, treq, n;
    rst = 1'b1;
    adc_valid0 = 1'b0; adc_data0 = 12'd0;
    adc_valid1 = 1'b0; adc_data1 = 12'd0;
    for (int i = 0; i < 4; i++) mute0[i] = 1'b0;
    set_tab(2048, 2048, 2048, 2048);
    repeat (2) @(negedge clk);
    check("rst_req", int'(adc_req0), 0);
    check("rst_audio", int'(audio_out0), 0);
    check("rst_valid", int'(audio_valid0), 0);
    check("rst_overrun", int'(overrun0), 0);
    check("rst_timeout", int'(timeout0), 0);
    rst = 1'b0;

    // Midscale input, cadence, latency, and a stray strobe while idle.
    wait_emit("mid1", v);
    check("mid1_value", v, 0);
    check("latency", cyc - vcyc, 2);
    t1 = cyc;
    spur_cyc = cyc + 3;
    wait_emit("mid2", v);
    check("mid2_value", v, 0);
    check("interval", cyc - t1, 64);
    check("slow_delay", e1_first - e0_first, 16);
    check("slow_value", a1_first, 59);
    check("slow_overruns", ovr1, 1);
    check("fast_overruns", ovr0, 0);
    spur_cyc = -1;

    set_tab(4095, 4095, 4095, 4095);
    do_reset();
    wait_emit("full", v);
    check("full_value", v, 127);
    repeat (10) @(negedge clk);
    check("hold", $signed(audio_out0), 127);

    set_tab(0, 0, 0, 0);
    do_reset();
    wait_emit("zero", v);
    check("zero_value", v, -128);

    set_tab(1000, 3000, 1000, 3000);
    do_reset();
    wait_emit("alt", v);
    check("alt_value", v, -3);

    // Fourth request of the block gets no answer and must reuse 2560.
    set_tab(2560, 2560, 2560, 2560);
    mute0[3] = 1'b1;
    do_reset();
    n = 0;
    while (!(adc_req0 && pos0 == 3) && n < 300) begin
      @(negedge clk);
      n++;
    end
    treq = cyc;
    n = 0;
    while (!timeout0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("timeout_delay", cyc - treq, 8);
    wait_emit("tmo", v);
    check("tmo_value", v, 32);
    mute0[3] = 1'b0;

    // Reset two cycles into the second request, after one 4095 sample was accumulated.
    set_tab(4095, 4095, 4095, 4095);
    do_reset();
    n = 0;
    while (!(adc_req0 && pos0 == 1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("pre_rst_req", int'(adc_req0), 1);
    rst = 1'b1;
    #1;
    check("async_req_drop", int'(adc_req0), 0);
    repeat (2) @(negedge clk);
    set_tab(2048, 2048, 2048, 2048);
    rst = 1'b0;
    wait_emit("post_rst", v);
    check("post_rst_value", v, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_decimator.md
AUDIO_DECIMATOR -- requirements
Module: audio_decimator

Interface
REQ-001 Parameter CYCLES_PER_REQ, default 1024: clk_in cycles between ADC conversion requests; 96 kHz at 98.304 MHz.
REQ-002 Parameter DECIM, default 8: raw samples averaged per output; power of two, 2..64.
REQ-003 Parameter TIMEOUT, default 64: maximum clk_in cycles to wait for an ADC response.
REQ-004 clk_in  input  1  the single system clock.
REQ-005 rst_in  input  1  reset, asynchronous, active-high.
REQ-006 adc_req_out  output  1  conversion request, held high until response or timeout.
REQ-007 adc_data_in  input  12  unsigned ADC sample, offset binary, midscale 2048.
REQ-008 adc_valid_in  input  1  one-cycle strobe qualifying adc_data_in.
REQ-009 audio_out  output  8  signed decimated sample, drives the recorder's audio_in.
REQ-010 audio_valid_out  output  1  one-cycle strobe qualifying audio_out, drives the recorder's audio_valid_in.
REQ-011 overrun_out  output  1  one-cycle strobe: a request tick arrived while the previous request was outstanding.
REQ-012 timeout_out  output  1  one-cycle strobe: an ADC request expired without a response.

Function
REQ-013 The tick counter SHALL run freely modulo CYCLES_PER_REQ and SHALL fire one tick per wrap.
REQ-014 FSM states SHALL be IDLE, WAIT_ADC, ACCUM and EMIT.
REQ-015 IDLE: on a tick, go to WAIT_ADC with adc_req_out=1 from the next cycle.
REQ-016 WAIT_ADC: on adc_valid_in, latch adc_data_in as last_raw and go to ACCUM. After TIMEOUT cycles with no strobe, reuse the previous last_raw, pulse timeout_out and go to ACCUM. adc_req_out=0 on exit.
REQ-017 ACCUM (one cycle): add last_raw to an accumulator 12+log2(DECIM) bits wide and increment the sample count. At count==DECIM go to EMIT, else go to IDLE.
REQ-018 EMIT (one cycle): avg = accumulator >> log2(DECIM); diff = avg - offset, signed 13 bits; audio_out = diff >>> 4, saturated to [-128,127].
REQ-019 EMIT SHALL also pulse audio_valid_out, clear the accumulator and count, and go to IDLE.
REQ-020 Latency: audio_valid_out SHALL rise exactly 2 cycles after the adc_valid_in that delivered the DECIM-th sample.
REQ-021 adc_valid_in outside WAIT_ADC SHALL be ignored, with no state change.
REQ-022 A tick in any state other than IDLE SHALL be dropped and SHALL pulse overrun_out; the next request waits for the following tick.
REQ-023 audio_out SHALL hold its value between strobes.
REQ-024 Accumulator overflow SHALL be impossible by width (DECIM×4095 fits).

Reset
REQ-025 While rst_in is high: state=IDLE, tick counter=0, accumulator=0, count=0, last_raw=2048.
REQ-026 While rst_in is high: audio_out=0, audio_valid_out=0, adc_req_out=0, overrun_out=0, timeout_out=0.
REQ-027 Reset mid-request SHALL drop adc_req_out asynchronously and discard the partial accumulation; the first tick after release starts a fresh block.

Configuration
REQ-028 Macro DECIM_DC_TRACK_EN defined: offset is a 12.8 fixed-point register, reset 2048.0, updated in EMIT as offset += (avg - offset) >>> 8, using the integer part in REQ-018.
REQ-029 Macro DECIM_DC_TRACK_EN undefined: offset is the constant 2048 and no tracking register exists.

Structure
REQ-030 Shared package audio_pkg SHALL hold the FSM state enum, the sample width constants ADC_W=12 and AUDIO_W=8, and ADC_MIDSCALE=2048.
REQ-031 One sub-module SHALL be used: req_ticker, holding the CYCLES_PER_REQ counter and the tick output. All other logic stays in this module.

Verification
Bench setup: CYCLES_PER_REQ=16, DECIM=4, TIMEOUT=8; the ADC model responds 3 cycles after request.
REQ-032 Constant 2048 -> audio_out=0, one audio_valid_out every 64 cycles.
REQ-033 Constant 4095 -> 127; constant 0 -> -128.
REQ-034 Samples 1000,3000,1000,3000 -> avg 2000 -> audio_out=-3 (-48>>>4).
REQ-035 ADC silent for one request, last_raw=2560 -> timeout_out pulses after 8 cycles; the block averages 2560 and outputs 32.
REQ-036 ADC response delayed 20 cycles -> overrun_out pulses once; the sample is still accepted; the following output is 16 cycles late.
REQ-037 rst_in asserted 2 cycles after adc_req_out rises -> adc_req_out falls asynchronously; the next block contains only post-reset samples.
